// File: rtl/enable_tick_gen.sv
// Start/stop push-button controlled enable-strobe generator: synchronizes and
// debounces two raw buttons, then runs a div+1 prescaler while in RUN.
module enable_tick_gen #(
    parameter int DIV_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_btn,
    input  logic                 stop_btn,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 enable,
    output logic                 running,
    output logic                 fsm_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // bit 0 = start, bit 1 = stop throughout the button path
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt [2];
    logic          start_evt;
    logic          stop_evt;

    state_t                 state;
    state_t                 state_nxt;
    logic [DIV_WIDTH-1:0]   presc;
    logic [DIV_WIDTH-1:0]   presc_nxt;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_q_nxt;
    logic                   enable_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {stop_btn, start_btn};
            sync2 <= sync1;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign start_evt = deb[0] & ~deb_d[0];
    assign stop_evt  = deb[1] & ~deb_d[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stop has priority over start in either state.
    always_comb begin
        state_nxt = state;
        if (stop_evt) begin
            state_nxt = IDLE;
        end else if (start_evt) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        presc_nxt  = '0;
        div_q_nxt  = div_q;
        enable_nxt = 1'b0;
        if (stop_evt) begin
            presc_nxt = '0;
        end else if (start_evt) begin
            div_q_nxt = div;
        end else if (state == RUN) begin
            if (presc == div_q) begin
                enable_nxt = 1'b1;
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc   <= '0;
            div_q   <= '0;
            enable  <= 1'b0;
            running <= 1'b0;
        end else begin
            presc   <= presc_nxt;
            div_q   <= div_q_nxt;
            enable  <= enable_nxt;
            running <= (state_nxt == RUN);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_enable_tick_gen.sv
// Self-checking bench for enable_tick_gen: directed scenarios plus random button
// activity, compared every cycle against a time-based reference model.
module tb_enable_tick_gen;

    localparam int DW   = 8;
    localparam int DB   = 4;
    localparam int MAXE = 16384;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start_btn = 1'b0;
    logic          stop_btn  = 1'b0;
    logic [DW-1:0] div       = '0;
    logic          enable;
    logic          running;
    logic          fsm_state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    enable_tick_gen #(.DIV_WIDTH(DW), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .div       (div),
        .enable    (enable),
        .running   (running),
        .fsm_state (fsm_state)
    );

    // downstream 4-bit counter driven by the enable strobe
    logic [3:0] dcnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) dcnt <= '0;
        else if (enable) dcnt <= dcnt + 4'd1;
    end

    // Reference model: raw samples per edge, debounced level from a window of
    // synchronized samples, enable times from absolute edge arithmetic.
    int t        = 0;
    int rst_edge = 0;
    bit hist [2][MAXE];
    bit m_deb [2];
    bit m_deb_d [2];
    bit m_run = 0;
    bit m_en  = 0;
    int next_en = 0;
    int period  = 1;

    function automatic bit samp(int b, int i);
        if (i <= rst_edge) return 1'b0;
        return hist[b][i];
    endfunction

    task automatic model_clear();
        m_run = 0;
        m_en  = 0;
        for (int b = 0; b < 2; b++) begin
            m_deb[b]   = 0;
            m_deb_d[b] = 0;
        end
        rst_edge = t;
    endtask

    task automatic model_edge();
        bit s_evt, p_evt, flip;
        t++;
        if (t >= MAXE) begin
            $display("FAIL edge_budget: edge %0d exceeds model capacity %0d", t, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        hist[0][t] = start_btn;
        hist[1][t] = stop_btn;
        if (!reset) begin
            model_clear();
            return;
        end
        s_evt = m_deb[0] & ~m_deb_d[0];
        p_evt = m_deb[1] & ~m_deb_d[1];
        for (int b = 0; b < 2; b++) begin
            m_deb_d[b] = m_deb[b];
            flip = 1;
            for (int k = 2; k <= DB + 1; k++) begin
                if (samp(b, t - k) == m_deb[b]) flip = 0;
            end
            if (flip) m_deb[b] = ~m_deb[b];
        end
        if (p_evt) begin
            m_run = 0;
            m_en  = 0;
        end else if (s_evt) begin
            m_run   = 1;
            period  = int'(div) + 1;
            next_en = t + period;
            m_en    = 0;
        end else if (m_run && t == next_en) begin
            m_en    = 1;
            next_en = next_en + period;
        end else begin
            m_en = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d (edge %0d)", tag, obs, exp, t);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("enable", {31'd0, enable}, {31'd0, m_en});
        check("running", {31'd0, running}, {31'd0, m_run});
        check("fsm_state", {31'd0, fsm_state}, {31'd0, m_run});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input int which, input int len);
        if (which == 0 || which == 2) start_btn = 1'b1;
        if (which == 1 || which == 2) stop_btn  = 1'b1;
        run(len);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
    endtask

    // Counts edges from the next sampling edge until running rises.
    task automatic start_latency(input string tag);
        int e, guard;
        e = t + 1;
        guard = 0;
        while (running !== 1'b1 && guard < 30) begin
            cycle();
            guard++;
        end
        check(tag, t - e, DB + 2);
    endtask

    task automatic collect_enables(input int want, input int budget, output int edges[$]);
        int guard;
        edges = {};
        guard = 0;
        while (edges.size() < want && guard < budget) begin
            cycle();
            if (enable === 1'b1) edges.push_back(t);
            guard++;
        end
        check("enable_count", edges.size(), want);
    endtask

    initial begin
        int en_q[$];
        int e;
        logic [3:0] d0;

        // reset asserted with buttons toggling
        #1 reset = 1'b0;
        #1;
        check("rst_enable", {31'd0, enable}, 0);
        check("rst_running", {31'd0, running}, 0);
        for (int i = 0; i < 4; i++) begin
            start_btn = 1'(i);
            stop_btn  = 1'(i >> 1);
            cycle();
        end
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        run(2);
        reset = 1'b1;
        run(3);

        // div=3: running at E+6, enables at E+10/14/18, counter +1 per 4 cycles
        div = 8'd3;
        e = t + 1;
        start_btn = 1'b1;
        start_latency("start_latency");
        start_btn = 1'b0;
        collect_enables(3, 40, en_q);
        if (en_q.size() == 3) begin
            check("first_enable", en_q[0] - e, 10);
            check("second_enable", en_q[1] - e, 14);
            check("third_enable", en_q[2] - e, 18);
        end
        d0 = dcnt;
        run(16);
        check("down_cnt", {28'd0, 4'(dcnt - d0)}, 4);

        // stop while running
        press(1, 6);
        run(6);
        check("stop_running", {31'd0, running}, 0);

        // short pulse rejected, DB-cycle pulse accepted
        press(0, DB - 1);
        run(10);
        check("short_pulse", {31'd0, running}, 0);
        press(0, DB);
        run(8);
        check("min_pulse", {31'd0, running}, 1);

        // simultaneous press: stop wins
        press(1, 6);
        run(8);
        press(2, 6);
        run(8);
        check("both_pressed", {31'd0, running}, 0);

        // random button activity with small divide values
        repeat (40) begin
            case ($urandom_range(0, 4))
                0: press(0, $urandom_range(1, 8));
                1: press(1, $urandom_range(1, 8));
                2: press(2, $urandom_range(1, 8));
                3: div = 8'($urandom_range(0, 15));
                default: ;
            endcase
            run($urandom_range(2, 14));
        end

        // div=0: enable every cycle
        press(1, 6);
        run(6);
        div = 8'd0;
        press(0, 6);
        run(3);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("div0_enable", {31'd0, enable}, 1);
        end

        // div=255: period 256, unaffected by a div change mid-run
        div = 8'd255;
        press(0, 6);
        collect_enables(1, 300, en_q);
        div = 8'd7;
        collect_enables(1, 300, en_q);
        e = t;
        collect_enables(1, 300, en_q);
        if (en_q.size() == 1) check("period_255", en_q[0] - e, 256);

        // asynchronous reset between edges while running
        div = 8'd2;
        press(0, 6);
        run(10);
        check("pre_reset_running", {31'd0, running}, 1);
        #3 reset = 1'b0;
        model_clear();
        #1;
        check("async_enable", {31'd0, enable}, 0);
        check("async_running", {31'd0, running}, 0);
        run(3);
        reset = 1'b1;
        run(30);
        check("post_reset_idle", {31'd0, running}, 0);

        // reset released with start already held
        reset = 1'b0;
        model_clear();
        start_btn = 1'b1;
        run(2);
        reset = 1'b1;
        start_latency("held_latency");
        start_btn = 1'b0;
        run(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enable_tick_gen.md
ENABLE_TICK_GEN -- requirements
Module: enable_tick_gen

Interface
REQ-001 Parameter DIV_WIDTH, default 8, width of prescaler divide value.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4 (legal range 2..255), consecutive stable cycles required to accept a button level change.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start_btn  input  1  raw, asynchronous start push-button.
REQ-006 stop_btn  input  1  raw, asynchronous stop push-button.
REQ-007 div  input  DIV_WIDTH  divide value; enable period = div+1 cycles.
REQ-008 enable  output  1  registered one-cycle strobe driving the downstream 4-bit counter's enable input.
REQ-009 running  output  1  registered, high while FSM is in RUN.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each synchronized button SHALL feed a debouncer: a per-button counter increments each cycle the synchronized level differs from the debounced level, clears when they match; the debounced level SHALL flip on the edge at which the counter equals DEBOUNCE_CYCLES-1 with mismatch still present.
REQ-012 Pulses shorter than DEBOUNCE_CYCLES cycles at the synchronizer output SHALL NOT change the debounced level.
REQ-013 start_evt / stop_evt SHALL be one-cycle strobes on the rising edge of the respective debounced level; falling edges produce no event.
REQ-014 Button held high from sampling edge E: running SHALL rise at edge E+DEBOUNCE_CYCLES+2.
REQ-015 FSM states: IDLE, RUN; reset state IDLE.
REQ-016 IDLE -> RUN on start_evt without stop_evt; div captured into div_q and prescaler cleared to 0 on that edge.
REQ-017 RUN -> IDLE on stop_evt; prescaler cleared, enable forced 0 on that edge.
REQ-018 Simultaneous start_evt and stop_evt: stop wins in both states.
REQ-019 start_evt while in RUN: stays RUN, re-captures div, clears prescaler; no enable on that edge.
REQ-020 In RUN, prescaler SHALL increment each cycle and wrap to 0 on the edge where it equals div_q; enable SHALL be registered high on that same edge, for exactly one cycle.
REQ-021 First enable SHALL go high div_q+1 edges after the edge entering RUN; thereafter period exactly div_q+1 cycles.
REQ-022 div_q=0: enable SHALL be high every cycle in RUN starting one edge after entry.
REQ-023 Changes on div during RUN SHALL be ignored until next RUN entry or restart.
REQ-024 In IDLE, enable SHALL be 0 and prescaler held at 0.
REQ-025 div_q = all-ones SHALL work with no overflow (prescaler width DIV_WIDTH).

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) clear enable=0, running=0, state IDLE, prescaler=0, div_q=0, synchronizers=0, debounced levels=0, debounce counters=0.
REQ-027 Reset deasserted with a button already held high SHALL yield a start/stop event after normal debounce latency (REQ-014).
REQ-028 Reset asserted mid-RUN SHALL drop enable and running in the same cycle, with no further enable until a new start_evt.

Verification
REQ-029 reset=0 for 30 ns with buttons toggling -> enable=0, running=0 throughout.
REQ-030 div=3, DEBOUNCE_CYCLES=4, start_btn high from edge E -> running=1 at E+6; enable high at E+10, E+14, E+18; downstream counter advances 1 per 4 cycles.
REQ-031 start_btn high 3 cycles then low -> running stays 0; 4 cycles -> running rises.
REQ-032 While running, stop_btn pressed -> running and enable 0 on stop_evt edge; simultaneous start+stop press -> running stays 0.
REQ-033 div=0 -> enable continuously high in RUN; div=255 -> period 256 cycles; changing div mid-RUN leaves period unchanged.
REQ-034 reset=0 asserted mid-RUN between clock edges -> enable, running fall immediately; after release no enable until a new start press.
